// File: rtl/arf_frame_sequencer_if.sv
// Sample-in / frame-out / result-out bundle for the ARF frame sequencer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface arf_frame_sequencer_if;
  localparam int DATA_W = 16;
  localparam int RES_W  = 64;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  logic [DATA_W-1:0] frame_0;
  logic [DATA_W-1:0] frame_1;
  logic [DATA_W-1:0] frame_2;
  logic [DATA_W-1:0] frame_3;
  logic [DATA_W-1:0] frame_4;
  logic [DATA_W-1:0] frame_5;
  logic [DATA_W-1:0] frame_6;
  logic [DATA_W-1:0] frame_7;

  logic [RES_W-1:0]  res_27;
  logic [RES_W-1:0]  res_28;
  logic [RES_W-1:0]  m_res_27;
  logic [RES_W-1:0]  m_res_28;
  logic [7:0]        m_frame_id;
  logic              m_valid;
  logic              m_ready;

  modport slave (
    input  s_data, s_valid, res_27, res_28, m_ready,
    output s_ready, frame_0, frame_1, frame_2, frame_3, frame_4, frame_5, frame_6, frame_7,
           m_res_27, m_res_28, m_frame_id, m_valid
  );

  modport master (
    output s_data, s_valid, res_27, res_28, m_ready,
    input  s_ready, frame_0, frame_1, frame_2, frame_3, frame_4, frame_5, frame_6, frame_7,
           m_res_27, m_res_28, m_frame_id, m_valid
  );
endinterface

// File: rtl/arf_frame_sequencer.sv
// Collects 8-sample frames, holds them on the ARF datapath for SETTLE_CYC cycles, then
// registers the two results behind a valid/ready port. Macro ARF_PINGPONG_EN lets the next frame fill during SETTLE/OUT.
module arf_frame_sequencer #(
  parameter int SETTLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  arf_frame_sequencer_if.slave  bus
);
  localparam int DATA_W = 16;
  localparam int RES_W  = 64;
  localparam int SW     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] fill_q [8];
  logic [DATA_W-1:0] fill_d [8];
  logic [3:0]        fill_cnt_q, fill_cnt_d;
  logic [DATA_W-1:0] frame_q [8];
  logic [DATA_W-1:0] frame_d [8];
  logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
  logic [RES_W-1:0]  m_res_27_q, m_res_27_d;
  logic [RES_W-1:0]  m_res_28_q, m_res_28_d;
  logic [7:0]        m_frame_id_q, m_frame_id_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              m_valid_q, m_valid_d;
  logic              s_ready_q, s_ready_d;
  logic              accept;

  assign accept = bus.s_valid & s_ready_q;

  // Next-state, fill buffer and capture logic.
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    fill_cnt_d   = fill_cnt_q;
    frame_d      = frame_q;
    settle_cnt_d = settle_cnt_q;
    m_res_27_d   = m_res_27_q;
    m_res_28_d   = m_res_28_q;
    m_frame_id_d = m_frame_id_q;
    frame_cnt_d  = frame_cnt_q;
    m_valid_d    = m_valid_q;

    if (accept) begin
      fill_d[fill_cnt_q[2:0]] = bus.s_data;
      fill_cnt_d              = fill_cnt_q + 4'd1;
    end else begin
      fill_cnt_d = fill_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (fill_cnt_q == 4'd8) begin
          frame_d      = fill_q;
          fill_cnt_d   = 4'd0;
          settle_cnt_d = SW'(SETTLE_CYC);
          state_d      = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        settle_cnt_d = settle_cnt_q - SW'(1);
        if (settle_cnt_q == SW'(1)) begin
          m_res_27_d   = bus.res_27;
          m_res_28_d   = bus.res_28;
          m_frame_id_d = frame_cnt_q;
          frame_cnt_d  = frame_cnt_q + 8'd1;
          m_valid_d    = 1'b1;
          state_d      = ST_OUT;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_OUT: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // s_ready is registered from the next state so the port never glitches.
`ifdef ARF_PINGPONG_EN
    s_ready_d = (fill_cnt_d < 4'd8);
`else
    s_ready_d = (state_d == ST_IDLE) && (fill_cnt_d < 4'd8);
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fill_cnt_q   <= 4'd0;
      settle_cnt_q <= '0;
      m_res_27_q   <= 64'd0;
      m_res_28_q   <= 64'd0;
      m_frame_id_q <= 8'd0;
      frame_cnt_q  <= 8'd0;
      m_valid_q    <= 1'b0;
      s_ready_q    <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        fill_q[i]  <= 16'd0;
        frame_q[i] <= 16'd0;
      end
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      fill_cnt_q   <= fill_cnt_d;
      frame_q      <= frame_d;
      settle_cnt_q <= settle_cnt_d;
      m_res_27_q   <= m_res_27_d;
      m_res_28_q   <= m_res_28_d;
      m_frame_id_q <= m_frame_id_d;
      frame_cnt_q  <= frame_cnt_d;
      m_valid_q    <= m_valid_d;
      s_ready_q    <= s_ready_d;
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.frame_0    = frame_q[0];
  assign bus.frame_1    = frame_q[1];
  assign bus.frame_2    = frame_q[2];
  assign bus.frame_3    = frame_q[3];
  assign bus.frame_4    = frame_q[4];
  assign bus.frame_5    = frame_q[5];
  assign bus.frame_6    = frame_q[6];
  assign bus.frame_7    = frame_q[7];
  assign bus.m_res_27   = m_res_27_q;
  assign bus.m_res_28   = m_res_28_q;
  assign bus.m_frame_id = m_frame_id_q;
  assign bus.m_valid    = m_valid_q;
endmodule
